microwave_timer: RTL and testbench
==================================

# microwave_timer

BCD countdown timer for the microwave controller, feeding the `timer_done` input of `control` and consuming its magnetron output `Q` as `enable`. The operator keys in a cook time as four BCD digits, MM:SS, shifted in from the right while the magnetron is off. The timer counts down one second per `TICKS_PER_SEC` enabled clocks while the magnetron is on. It flags zero on `timer_done`, which forces the control block to reset the magnetron.

## Interface
- `TICKS_PER_SEC`, default 100: clock cycles per displayed second; must be ≥2.
- `BEEP_SECONDS`, default 3: beep duration in seconds. Present only with `MICROWAVE_BEEP_EN`.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `clear` input 1: synchronous clear, same signal as `control`'s `clear`.
- `enable` input 1: magnetron on (`control.Q`).
- `key_valid` input 1: one-cycle strobe; `key_digit` is valid while it is high.
- `key_digit` input 4: BCD digit 0–9.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones` output 4 each: current time as BCD, registered.
- `timer_done` output 1: high when all four digits are 0; decoded combinationally from the digit registers.
- `beep` output 1: end-of-cook beep. Present only with `MICROWAVE_BEEP_EN`.

## Operation
- Reset state:
  - all digits 0, so `timer_done`=1;
  - prescaler 0;
  - `beep`=0.
- Priority per edge, highest first: `reset`, then `clear`, then key entry, then countdown.
- `clear`=1:
  - digits ← 0 and prescaler ← 0;
  - `beep` ← 0;
  - any key strobe on the same cycle is discarded.
- Key entry:
  - Accepted only when `key_valid`=1, `enable`=0, `clear`=0 and `key_digit` ≤ 9.
  - An accepted key shifts the digits left: `min_tens`←`min_ones`, `min_ones`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←`key_digit`.
  - The old `min_tens` is lost.
  - Digits 10–15 are ignored, and so is any key while `enable`=1.
  - An accepted key cancels `beep`.
- `sec_tens` may hold 6–9 after entry (e.g. 00:99 means 99 s). It is not normalised. The countdown borrows correctly from such values.
- Prescaler:
  - Counts 0..`TICKS_PER_SEC`−1 only while `enable`=1 and `timer_done`=0.
  - Holds its value while `enable`=0, so a pause keeps the partial second.
  - On the terminal count it wraps to 0 and issues a one-cycle tick.
- Decrement on tick, BCD with borrow:
  - `sec_ones` 0 → 9 with borrow; else −1.
  - `sec_tens` on borrow: 0 → 5 with borrow; else −1.
  - `min_ones` on borrow: 0 → 9 with borrow; else −1.
  - `min_tens` on borrow: −1.
  - A tick never occurs at 00:00 because the prescaler is gated.
- Examples: 10:00 → 09:59; 01:00 → 00:59; 00:99 → 00:98.
- Keys and `enable` are not allowed to change digits in the same cycle, because entry requires `enable`=0.

## Timing
- Key entry latency: digit visible on the outputs 1 cycle after the strobe edge.
- `enable` rises before edge 0 with prescaler at 0: the first decrement lands at edge `TICKS_PER_SEC`−1. Display then changes every `TICKS_PER_SEC` enabled cycles.
- `timer_done` rises in the same cycle the digits become 00:00, which is the cycle after the final tick edge. `control` then drops `Q` combinationally.
- `clear` takes effect 1 cycle after assertion.
- `reset` is asynchronous: outputs go to their reset values immediately, even in the middle of a countdown.

## Configuration
- `MICROWAVE_BEEP_EN` defined:
  - Adds the `beep` port and the `BEEP_SECONDS` parameter.
  - `beep` rises on the edge where the digits transition from nonzero to 00:00 via a tick.
  - It stays high for `BEEP_SECONDS`×`TICKS_PER_SEC` cycles, counted by its own counter that runs regardless of `enable`.
  - It is cancelled early by `reset`, `clear` or an accepted key.
  - Reaching zero by `clear` or by `reset` does not beep.
- `MICROWAVE_BEEP_EN` undefined:
  - No `beep` port, no beep counter, no `BEEP_SECONDS`.
  - All other behaviour is identical.

## Test plan
The bench uses `TICKS_PER_SEC`=4 and `BEEP_SECONDS`=2.
- Reset check: assert `reset` mid-cycle → digits 00:00, `timer_done`=1 and `beep`=0 immediately, without waiting for a clock edge.
- Key entry: keys 1,2,3,4 with `enable`=0 → 12:34. Then key 5 → 23:45. Then key 12 → ignored, still 23:45. Then key 7 with `enable`=1 → ignored.
- Countdown with borrow: load 01:00, raise `enable` → 00:59 after 4 enabled cycles and 00:58 after 8.
- Pause: load 00:02, enable for 6 cycles (display 00:01), drop `enable` for 10 cycles (display holds), re-enable → 00:00 after 2 more cycles, `timer_done`=1, prescaler stops counting.
- Unnormalised entry and clear: load 00:99, count 1 s → 00:98; assert `clear` together with `key_valid`/key 5 → 00:00, key discarded.
- Beep (macro on): count 00:01 down to zero → `beep` high for exactly 8 cycles. Repeat, and press key 3 during the beep → `beep` drops on the next edge and the digits read 00:03.

Source files
------------

// File: rtl/microwave_timer.sv
// BCD MM:SS countdown timer for the microwave controller: keyed entry while idle,
// one-second countdown while the magnetron runs. Optional end-of-cook beep under MICROWAVE_BEEP_EN.
module microwave_timer #(
    parameter int unsigned TICKS_PER_SEC = 100
`ifdef MICROWAVE_BEEP_EN
    ,
    parameter int unsigned BEEP_SECONDS  = 3
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done
`ifdef MICROWAVE_BEEP_EN
    ,
    output logic       beep
`endif
);

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    logic [3:0]    min_tens_q, min_tens_d;
    logic [3:0]    min_ones_q, min_ones_d;
    logic [3:0]    sec_tens_q, sec_tens_d;
    logic [3:0]    sec_ones_q, sec_ones_d;
    logic [PW-1:0] presc_q, presc_d;

    logic       key_accept;
    logic       run;
    logic       tick;
    logic       borrow_so, borrow_st, borrow_mo;
    logic [3:0] dec_mt, dec_mo, dec_st, dec_so;

    assign min_tens   = min_tens_q;
    assign min_ones   = min_ones_q;
    assign sec_tens   = sec_tens_q;
    assign sec_ones   = sec_ones_q;
    assign timer_done = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                        (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);

    assign key_accept = key_valid && !enable && !clear && (key_digit <= 4'd9);
    // Gating on timer_done guarantees no tick is ever issued at 00:00.
    assign run        = enable && !timer_done;
    assign tick       = run && (presc_q == PRESC_LAST);

    // BCD decrement with borrow; sec_tens values 6-9 simply count down like any digit.
    always_comb begin
        borrow_so = (sec_ones_q == 4'd0);
        dec_so    = borrow_so ? 4'd9 : sec_ones_q - 4'd1;
        borrow_st = 1'b0;
        dec_st    = sec_tens_q;
        borrow_mo = 1'b0;
        dec_mo    = min_ones_q;
        dec_mt    = min_tens_q;
        if (borrow_so) begin
            borrow_st = (sec_tens_q == 4'd0);
            dec_st    = borrow_st ? 4'd5 : sec_tens_q - 4'd1;
        end
        if (borrow_st) begin
            borrow_mo = (min_ones_q == 4'd0);
            dec_mo    = borrow_mo ? 4'd9 : min_ones_q - 4'd1;
        end
        if (borrow_mo) begin
            dec_mt = min_tens_q - 4'd1;
        end
    end

    always_comb begin
        min_tens_d = min_tens_q;
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;
        presc_d    = presc_q;
        if (clear) begin
            min_tens_d = 4'd0;
            min_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            sec_ones_d = 4'd0;
            presc_d    = '0;
        end else if (key_accept) begin
            min_tens_d = min_ones_q;
            min_ones_d = sec_tens_q;
            sec_tens_d = sec_ones_q;
            sec_ones_d = key_digit;
        end else if (run) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                min_tens_d = dec_mt;
                min_ones_d = dec_mo;
                sec_tens_d = dec_st;
                sec_ones_d = dec_so;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            min_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            sec_ones_q <= 4'd0;
            presc_q    <= '0;
        end else begin
            min_tens_q <= min_tens_d;
            min_ones_q <= min_ones_d;
            sec_tens_q <= sec_tens_d;
            sec_ones_q <= sec_ones_d;
            presc_q    <= presc_d;
        end
    end

`ifdef MICROWAVE_BEEP_EN
    localparam int unsigned BEEP_CYCLES = BEEP_SECONDS * TICKS_PER_SEC;
    localparam int unsigned BW = $clog2(BEEP_CYCLES + 1);

    logic [BW-1:0] beep_cnt_q, beep_cnt_d;
    logic          dec_zero;

    assign dec_zero = (dec_mt == 4'd0) && (dec_mo == 4'd0) &&
                      (dec_st == 4'd0) && (dec_so == 4'd0);
    assign beep     = (beep_cnt_q != '0);

    // Only a tick landing on 00:00 starts the beep; clear/reset reaching zero stays silent.
    always_comb begin
        beep_cnt_d = beep_cnt_q;
        if (clear || key_accept) begin
            beep_cnt_d = '0;
        end else if (tick && dec_zero) begin
            beep_cnt_d = BW'(BEEP_CYCLES);
        end else if (beep_cnt_q != '0) begin
            beep_cnt_d = beep_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beep_cnt_q <= '0;
        end else begin
            beep_cnt_q <= beep_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_microwave_timer.sv
// Directed bench for microwave_timer with TICKS_PER_SEC=4, BEEP_SECONDS=2.
module tb_microwave_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       enable;
  logic       key_valid;
  logic [3:0] key_digit;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       timer_done;
`ifdef MICROWAVE_BEEP_EN
  logic       beep;
`endif
  logic [15:0] disp;

  int n_checks = 0;
  int n_fail   = 0;

  assign disp = {min_tens, min_ones, sec_tens, sec_ones};

  microwave_timer #(
    .TICKS_PER_SEC(4)
`ifdef MICROWAVE_BEEP_EN
    ,
    .BEEP_SECONDS(2)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .enable     (enable),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .timer_done (timer_done)
`ifdef MICROWAVE_BEEP_EN
    ,
    .beep       (beep)
`endif
  );

  // clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    step();
    key_valid = 1'b0;
    key_digit = 4'd0;
  endtask

  task automatic load4(input logic [15:0] t);
    key(t[15:12]);
    key(t[11:8]);
    key(t[7:4]);
    key(t[3:0]);
  endtask

  initial begin
    reset     = 1'b1;
    clear     = 1'b0;
    enable    = 1'b0;
    key_valid = 1'b0;
    key_digit = 4'd0;
    #12;
    check_eq("reset_digits", disp, 16'h0000);
    check_eq("reset_done", {15'd0, timer_done}, 16'd1);
    reset = 1'b0;
    step();

    // key entry
    load4(16'h1234);
    check_eq("key_1234", disp, 16'h1234);
    check_eq("key_done0", {15'd0, timer_done}, 16'd0);
    key(4'd5);
    check_eq("key_shift5", disp, 16'h2345);
    key(4'd12);
    check_eq("key_bad12", disp, 16'h2345);
    enable = 1'b1;
    key(4'd7);
    check_eq("key_enabled7", disp, 16'h2345);
    enable = 1'b0;

    // asynchronous reset mid-cycle
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_rst_digits", disp, 16'h0000);
    check_eq("async_rst_done", {15'd0, timer_done}, 16'd1);
`ifdef MICROWAVE_BEEP_EN
    check_eq("async_rst_beep", {15'd0, beep}, 16'd0);
`endif
    #1;
    reset = 1'b0;
    step();

    // 10:00 -> 09:59, first decrement on the 4th enabled edge
    load4(16'h1000);
    enable = 1'b1;
    steps(3);
    check_eq("cd_1000_hold", disp, 16'h1000);
    step();
    check_eq("cd_0959", disp, 16'h0959);
    enable = 1'b0;

    // 01:00 -> 00:59 -> 00:58
    load4(16'h0100);
    enable = 1'b1;
    steps(4);
    check_eq("cd_0059", disp, 16'h0059);
    steps(4);
    check_eq("cd_0058", disp, 16'h0058);
    enable = 1'b0;

    // pause keeps the partial second
    load4(16'h0002);
    enable = 1'b1;
    steps(6);
    check_eq("pause_run", disp, 16'h0001);
    enable = 1'b0;
    steps(10);
    check_eq("pause_hold", disp, 16'h0001);
    enable = 1'b1;
    step();
    check_eq("pause_resume1", disp, 16'h0001);
    step();
    check_eq("pause_zero", disp, 16'h0000);
    check_eq("pause_done", {15'd0, timer_done}, 16'd1);
    steps(3);
    check_eq("zero_stays", disp, 16'h0000);
    enable = 1'b0;

    // prescaler must have stayed at 0 while done
    load4(16'h0001);
    enable = 1'b1;
    steps(3);
    check_eq("presc_gated_hold", disp, 16'h0001);
    check_eq("presc_gated_done0", {15'd0, timer_done}, 16'd0);
    step();
    check_eq("presc_gated_zero", disp, 16'h0000);
    check_eq("presc_gated_done", {15'd0, timer_done}, 16'd1);
    enable = 1'b0;

`ifdef MICROWAVE_BEEP_EN
    // beep lasts exactly 8 cycles
    check_eq("beep_c1", {15'd0, beep}, 16'd1);
    for (int i = 2; i <= 8; i++) begin
      step();
      check_eq($sformatf("beep_c%0d", i), {15'd0, beep}, 16'd1);
    end
    step();
    check_eq("beep_off", {15'd0, beep}, 16'd0);

    // key during beep cancels it
    load4(16'h0001);
    enable = 1'b1;
    steps(4);
    check_eq("beep2_on", {15'd0, beep}, 16'd1);
    enable = 1'b0;
    steps(2);
    check_eq("beep2_still", {15'd0, beep}, 16'd1);
    key(4'd3);
    check_eq("beep2_cancel", {15'd0, beep}, 16'd0);
    check_eq("beep2_digits", disp, 16'h0003);
`endif

    // unnormalised entry counts down with borrow
    load4(16'h0099);
    enable = 1'b1;
    steps(4);
    check_eq("unnorm_0098", disp, 16'h0098);
    steps(2);
    enable = 1'b0;

    // clear wins over a key on the same cycle and zeroes the prescaler
    clear     = 1'b1;
    key_valid = 1'b1;
    key_digit = 4'd5;
    step();
    clear     = 1'b0;
    key_valid = 1'b0;
    key_digit = 4'd0;
    check_eq("clear_digits", disp, 16'h0000);
    check_eq("clear_done", {15'd0, timer_done}, 16'd1);
`ifdef MICROWAVE_BEEP_EN
    check_eq("clear_nobeep", {15'd0, beep}, 16'd0);
`endif
    load4(16'h0001);
    enable = 1'b1;
    steps(3);
    check_eq("clear_presc_hold", disp, 16'h0001);
    step();
    check_eq("clear_presc_zero", disp, 16'h0000);
    enable = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
